prbs4_checker: RTL

Receive-side checker for the 4-bit PRBS stream produced by the team's LFSR generator (recurrence b[n] = b[n-4] XOR b[n-3], period 15). It consumes one bit per valid cycle and self-synchronises to the incoming sequence. Once aligned, it runs a local reference generator and flags every bit that disagrees with it. It sits at the receive end of a link or loopback path and exposes lock status plus a saturating error count for built-in self-test.

---
 rtl/prbs4_pkg.sv | 10 +
 rtl/prbs4_if.sv | 14 +
 rtl/prbs4_step.sv | 13 +
 rtl/prbs4_checker.sv | 109 ++++++++++
 4 files changed

// File: rtl/prbs4_pkg.sv
// Shared types and constants for the PRBS-4 (x^4 + x^3 + 1) checker family.
package prbs4_pkg;

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam int unsigned LFSR_W = 4;
  localparam int unsigned TAP_A  = 3;
  localparam int unsigned TAP_B  = 2;

endpackage

// File: rtl/prbs4_if.sv
// Serial-bit receive bus between a link source and the PRBS-4 checker.
interface prbs4_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             din;
  logic             din_valid;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;

  modport master (output din, din_valid, clr_cnt, input locked, err, err_count);
  modport slave  (input din, din_valid, clr_cnt, output locked, err, err_count);
endinterface

// File: rtl/prbs4_step.sv
// One LFSR step: predicted next bit and the history advanced on that prediction.
module prbs4_step
  import prbs4_pkg::*;
(
  input  logic [LFSR_W-1:0] hist,
  output logic [LFSR_W:0]   step_out
);
  logic pred;

  assign pred     = hist[TAP_A] ^ hist[TAP_B];
  // {next history (newest bit in LSB), predicted bit}
  assign step_out = {hist[LFSR_W-2:0], pred, pred};
endmodule

// File: rtl/prbs4_checker.sv
// PRBS-4 receive checker: self-synchronises in HUNT, free-runs a reference in
// LOCKED and reports per-bit errors plus a saturating error count.
module prbs4_checker
  import prbs4_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic   clk,
  input  logic   rst,
  prbs4_if.slave bus
);
  localparam logic [2:0] FILL_FULL   = 3'(LFSR_W);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  hist_q, hist_d, hist_free;
  logic [2:0]         fill_q, fill_d;
  logic [7:0]         match_q, match_d;
  logic [7:0]         miss_q, miss_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pred;
  logic [LFSR_W:0]    step_out;

  prbs4_step u_step (
    .hist     (hist_q),
    .step_out (step_out)
  );

  assign {hist_free, pred} = step_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          hist_d = {hist_q[LFSR_W-2:0], bus.din};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 3'd1;
          end else if (bus.din == pred && hist_q != '0) begin
            if (match_q == LOCK_LAST) begin
              state_d = LOCKED;
              match_d = '0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Reference ignores din so one channel error costs exactly one miss.
          hist_d = hist_free;
          if (bus.din != pred) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (miss_q == UNLOCK_LAST) begin
              state_d = HUNT;
              fill_d  = '0;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (bus.clr_cnt) cnt_d = '0;
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err       = err_q;
  assign bus.err_count = cnt_q;
endmodule
